// File: rtl/serving_wb_ram_ctrl.sv
// serving_wb_ram_ctrl
// Bridges a 32-bit Wishbone slave port onto a byte-wide RAM with a
// one-cycle read latency. Each word access is split into four byte
// accesses. Writes take four byte cycles and then ack. Reads take four
// issue cycles plus one wait cycle for the last byte, and then ack.
//
// Ports
//   i_clk     clock; all state changes on its rising edge
//   i_rst_n   asynchronous active-low reset
//   i_wb_adr  Wishbone byte address (bits [1:0] ignored)
//   i_wb_dat  Wishbone write data
//   i_wb_sel  byte enables, bit k selects lane [8k+7:8k]
//   i_wb_we   1 = write, 0 = read
//   i_wb_cyc  request strobe
//   o_wb_rdt  read data, held between reads
//   o_wb_ack  one-cycle completion pulse
//   o_waddr   RAM write byte address
//   o_wdata   RAM write data
//   o_wen     RAM write enable
//   o_raddr   RAM read byte address
//   i_rdata   RAM read data, valid one cycle after o_raddr/o_ren
//   o_ren     RAM read enable
module serving_wb_ram_ctrl #(
    parameter int depth = 256,
    parameter int aw    = $clog2(depth)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [aw-1:0] i_wb_adr,
    input  logic [31:0]   i_wb_dat,
    input  logic [3:0]    i_wb_sel,
    input  logic          i_wb_we,
    input  logic          i_wb_cyc,
    output logic [31:0]   o_wb_rdt,
    output logic          o_wb_ack,
    output logic [aw-1:0] o_waddr,
    output logic [7:0]    o_wdata,
    output logic          o_wen,
    output logic [aw-1:0] o_raddr,
    input  logic [7:0]    i_rdata,
    output logic          o_ren
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        RDWAIT,
        ACK
    } state_t;

    state_t        state;
    logic [1:0]    cnt;
    logic [aw-3:0] adr_q;
    logic [31:0]   dat_q;
    logic [3:0]    sel_q;

    logic [1:0]    cnt_next;
    logic [1:0]    cnt_prev;

    // The low address bits never matter: every access covers a whole word.
    logic          unused_adr_bits;
    assign unused_adr_bits = &{1'b0, i_wb_adr[1:0]};

    assign cnt_next = cnt + 2'd1;
    assign cnt_prev = cnt - 2'd1;

    // All RAM-side outputs are registered. That means the value for byte
    // k+1 is loaded on the edge that ends byte k, and byte 0 is loaded on
    // the edge that accepts the request. Read data trails the issued
    // address by one cycle. So while byte k is being issued, the edge
    // captures byte k-1, and RDWAIT exists only to capture byte 3.
    // Word address and byte index are concatenated, never added, so the
    // top word cannot carry into word 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            cnt      <= 2'd0;
            adr_q    <= '0;
            dat_q    <= 32'd0;
            sel_q    <= 4'd0;
            o_wb_rdt <= 32'd0;
            o_wb_ack <= 1'b0;
            o_waddr  <= '0;
            o_wdata  <= 8'd0;
            o_wen    <= 1'b0;
            o_raddr  <= '0;
            o_ren    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_wb_ack <= 1'b0;
                    if (i_wb_cyc) begin
                        adr_q <= i_wb_adr[aw-1:2];
                        dat_q <= i_wb_dat;
                        sel_q <= i_wb_sel;
                        cnt   <= 2'd0;
                        if (i_wb_we) begin
                            state   <= WRITE;
                            o_waddr <= {i_wb_adr[aw-1:2], 2'b00};
                            o_wdata <= i_wb_dat[7:0];
                            o_wen   <= i_wb_sel[0];
                        end else begin
                            state   <= READ;
                            o_raddr <= {i_wb_adr[aw-1:2], 2'b00};
                            o_ren   <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (cnt == 2'd3) begin
                        o_wen    <= 1'b0;
                        o_wb_ack <= 1'b1;
                        state    <= ACK;
                    end else begin
                        cnt     <= cnt_next;
                        o_waddr <= {adr_q, cnt_next};
                        o_wdata <= dat_q[{cnt_next, 3'b000} +: 8];
                        o_wen   <= sel_q[cnt_next];
                    end
                end
                READ: begin
                    if (cnt != 2'd0) begin
                        o_wb_rdt[{cnt_prev, 3'b000} +: 8] <= i_rdata;
                    end
                    if (cnt == 2'd3) begin
                        o_ren <= 1'b0;
                        state <= RDWAIT;
                    end else begin
                        cnt     <= cnt_next;
                        o_raddr <= {adr_q, cnt_next};
                    end
                end
                RDWAIT: begin
                    o_wb_rdt[31:24] <= i_rdata;
                    o_wb_ack        <= 1'b1;
                    state           <= ACK;
                end
                ACK: begin
                    o_wb_ack <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serving_wb_ram_ctrl.sv
// tb_serving_wb_ram_ctrl
// Self-checking bench for serving_wb_ram_ctrl. A behavioural one-cycle
// RAM sits on the byte port. A separate reference byte array predicts
// the read results. Every transaction pushes its expected outcome into a
// scoreboard queue, and that entry is popped when the DUT acks.
module tb_serving_wb_ram_ctrl;

    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic          i_clk;
    logic          i_rst_n;
    logic [AW-1:0] i_wb_adr;
    logic [31:0]   i_wb_dat;
    logic [3:0]    i_wb_sel;
    logic          i_wb_we;
    logic          i_wb_cyc;
    logic [31:0]   o_wb_rdt;
    logic          o_wb_ack;
    logic [AW-1:0] o_waddr;
    logic [7:0]    o_wdata;
    logic          o_wen;
    logic [AW-1:0] o_raddr;
    logic [7:0]    i_rdata;
    logic          o_ren;

    typedef struct {
        logic        is_read;
        logic [31:0] data;
        int          exp_edge;
        int          wen_n;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] wlog[$];
    logic [7:0]  rlog[$];

    logic [7:0]  ram[DEPTH];
    logic [7:0]  ref_mem[DEPTH];

    int          tests;
    int          fails;
    int          edge_cnt;
    int          wen_cnt;
    int          ren_cnt;
    logic [31:0] last_rdt;

    serving_wb_ram_ctrl #(.depth(DEPTH), .aw(AW)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_wb_adr (i_wb_adr),
        .i_wb_dat (i_wb_dat),
        .i_wb_sel (i_wb_sel),
        .i_wb_we  (i_wb_we),
        .i_wb_cyc (i_wb_cyc),
        .o_wb_rdt (o_wb_rdt),
        .o_wb_ack (o_wb_ack),
        .o_waddr  (o_waddr),
        .o_wdata  (o_wdata),
        .o_wen    (o_wen),
        .o_raddr  (o_raddr),
        .i_rdata  (i_rdata),
        .o_ren    (o_ren)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Rising-edge counter used to time-stamp acks against their requests.
    always @(posedge i_clk) begin
        edge_cnt++;
    end

    // Behavioural byte RAM with a one-cycle registered read.
    always @(posedge i_clk) begin
        if (o_wen) ram[o_waddr] <= o_wdata;
        if (o_ren) i_rdata <= ram[o_raddr];
    end

    // Global bound so that a stuck DUT can never hang the run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Count one comparison and report it if it does not match.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor on the falling edge. It checks that the two enables never
    // overlap, logs the RAM traffic, and retires one scoreboard entry per ack.
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            checkOutput("wen_ren_overlap", {31'd0, o_wen & o_ren}, 32'd0);
            if (o_wen) begin
                wen_cnt++;
                wlog.push_back({o_waddr, o_wdata});
            end
            if (o_ren) begin
                ren_cnt++;
                rlog.push_back(o_raddr);
            end
            if (o_wb_ack) begin
                if (sb.size() == 0) begin
                    checkOutput("spurious_ack", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("ack_latency", edge_cnt, e.exp_edge);
                    if (e.is_read) begin
                        checkOutput("read_data", o_wb_rdt, e.data);
                        checkOutput("ren_cycles", ren_cnt, 32'd4);
                        last_rdt = e.data;
                    end else begin
                        checkOutput("wen_cycles", wen_cnt, e.wen_n);
                        checkOutput("rdt_hold_on_write", o_wb_rdt, last_rdt);
                    end
                end
                wen_cnt = 0;
                ren_cnt = 0;
            end
        end
    end

    // Run one transaction. Call this at a falling edge while the DUT is idle.
    // The task updates the reference model and pushes the expected outcome.
    // It holds cyc for 'hold' edges, then drops cyc and scrambles the other
    // inputs, waits (with a bound) for the ack, and returns one cycle later.
    task automatic applyStimulus(input logic we, input logic [7:0] adr, input logic [31:0] dat,
                                 input logic [3:0] sel, input int hold);
        exp_t        e;
        logic [7:0]  a;
        bit          got;
        a = {adr[7:2], 2'b00};
        e.is_read  = !we;
        e.exp_edge = edge_cnt + (we ? 5 : 6);
        e.wen_n    = $countones(sel);
        e.data     = 32'd0;
        if (we) begin
            for (int k = 0; k < 4; k++) begin
                if (sel[k]) ref_mem[a + 8'(k)] = dat[8*k +: 8];
            end
        end else begin
            e.data = {ref_mem[a + 8'd3], ref_mem[a + 8'd2], ref_mem[a + 8'd1], ref_mem[a]};
        end
        sb.push_back(e);
        i_wb_adr = adr;
        i_wb_dat = dat;
        i_wb_sel = sel;
        i_wb_we  = we;
        i_wb_cyc = 1'b1;
        repeat (hold) @(posedge i_clk);
        #1;
        i_wb_cyc = 1'b0;
        i_wb_adr = 8'($urandom);
        i_wb_dat = $urandom;
        i_wb_sel = 4'($urandom);
        i_wb_we  = 1'($urandom);
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge i_clk);
            if (o_wb_ack) got = 1'b1;
        end
        if (!got) begin
            checkOutput("ack_timeout", 32'd0, 32'd1);
            if (sb.size() > 0) sb.delete(sb.size() - 1);
        end
        @(negedge i_clk);
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        edge_cnt = 0;
        wen_cnt  = 0;
        ren_cnt  = 0;
        last_rdt = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]     = 8'd0;
            ref_mem[i] = 8'd0;
        end
        i_rst_n  = 1'b0;
        i_wb_adr = 8'h10;
        i_wb_dat = 32'hFFFF_FFFF;
        i_wb_sel = 4'hF;
        i_wb_we  = 1'b1;
        i_wb_cyc = 1'b1;

        // Reset state, checked while a request is being offered.
        repeat (3) @(posedge i_clk);
        #1;
        checkOutput("reset_ack", {31'd0, o_wb_ack}, 32'd0);
        checkOutput("reset_wen", {31'd0, o_wen}, 32'd0);
        checkOutput("reset_ren", {31'd0, o_ren}, 32'd0);
        checkOutput("reset_rdt", o_wb_rdt, 32'd0);
        checkOutput("reset_waddr", {24'd0, o_waddr}, 32'd0);
        checkOutput("reset_raddr", {24'd0, o_raddr}, 32'd0);
        checkOutput("reset_wdata", {24'd0, o_wdata}, 32'd0);
        i_wb_cyc = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Full word write. Bytes go to 0x10..0x13, little-endian.
        wlog.delete();
        applyStimulus(1'b1, 8'h10, 32'hDEAD_BEEF, 4'hF, 1);
        checkOutput("w035_count", wlog.size(), 32'd4);
        if (wlog.size() == 4) begin
            checkOutput("w035_b0", {16'd0, wlog[0]}, 32'h10EF);
            checkOutput("w035_b1", {16'd0, wlog[1]}, 32'h11BE);
            checkOutput("w035_b2", {16'd0, wlog[2]}, 32'h12AD);
            checkOutput("w035_b3", {16'd0, wlog[3]}, 32'h13DE);
        end

        // Read back. The sel value is ignored for reads.
        applyStimulus(1'b0, 8'h10, 32'd0, 4'h1, 1);

        // Partial write over a pre-filled word, then read it back.
        applyStimulus(1'b1, 8'h20, 32'hAAAA_AAAA, 4'hF, 1);
        applyStimulus(1'b1, 8'h20, 32'h1122_3344, 4'b0101, 1);
        applyStimulus(1'b0, 8'h20, 32'd0, 4'h0, 1);
        checkOutput("partial_word", o_wb_rdt, 32'hAA22_AA44);

        // Top word, with cyc dropped only in the second busy cycle.
        applyStimulus(1'b1, 8'hFC, 32'h0102_0304, 4'hF, 1);
        rlog.delete();
        applyStimulus(1'b0, 8'hFE, 32'd0, 4'h0, 2);
        checkOutput("top_count", rlog.size(), 32'd4);
        if (rlog.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                checkOutput("top_raddr", {24'd0, rlog[k]}, 32'hFC + k);
            end
        end

        // A write with no byte enables still takes 4 cycles and acks.
        applyStimulus(1'b1, 8'h20, 32'h5555_5555, 4'h0, 1);
        applyStimulus(1'b0, 8'h20, 32'd0, 4'hF, 1);

        // Reset during a write. Byte 0 reaches the RAM; nothing after it does.
        i_wb_adr = 8'h40;
        i_wb_dat = 32'h5566_7788;
        i_wb_sel = 4'hF;
        i_wb_we  = 1'b1;
        i_wb_cyc = 1'b1;
        @(posedge i_clk);
        #1;
        i_wb_cyc = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b0;
        #1;
        checkOutput("abort_wen", {31'd0, o_wen}, 32'd0);
        checkOutput("abort_ack", {31'd0, o_wb_ack}, 32'd0);
        checkOutput("abort_waddr", {24'd0, o_waddr}, 32'd0);
        checkOutput("abort_wdata", {24'd0, o_wdata}, 32'd0);
        checkOutput("abort_rdt", o_wb_rdt, 32'd0);
        ref_mem[8'h40] = 8'h88;
        last_rdt = 32'd0;
        repeat (3) @(posedge i_clk);
        wen_cnt = 0;
        ren_cnt = 0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        applyStimulus(1'b0, 8'h40, 32'd0, 4'hF, 1);

        // Random mix against the scoreboard.
        for (int n = 0; n < 1000; n++) begin
            applyStimulus(1'($urandom), 8'($urandom), $urandom, 4'($urandom), $urandom_range(1, 4));
        end

        checkOutput("scoreboard_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serving_wb_ram_ctrl.md
SERVING_WB_RAM_CTRL -- requirements
Module: serving_wb_ram_ctrl

Interface
REQ-001 Parameter depth, default 256, SHALL give the RAM size in bytes; it SHALL be a multiple of 4.
REQ-002 Parameter aw, default $clog2(depth), SHALL give the byte-address width; it SHALL be at least 2.
REQ-003 i_clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 i_rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 i_wb_adr  input  aw  SHALL be the Wishbone byte address; bits [1:0] are ignored.
REQ-006 i_wb_dat  input  32  SHALL be the Wishbone write data.
REQ-007 i_wb_sel  input  4  SHALL be the byte enables; bit k selects byte lane [8k+7:8k].
REQ-008 i_wb_we  input  1  SHALL select a write (1) or a read (0).
REQ-009 i_wb_cyc  input  1  SHALL be the request strobe.
REQ-010 o_wb_rdt  output  32  SHALL be the read data.
REQ-011 o_wb_ack  output  1  SHALL be the one-cycle completion pulse.
REQ-012 o_waddr  output  aw  SHALL be the RAM write byte address.
REQ-013 o_wdata  output  8  SHALL be the RAM write data.
REQ-014 o_wen  output  1  SHALL be the RAM write enable.
REQ-015 o_raddr  output  aw  SHALL be the RAM read byte address.
REQ-016 i_rdata  input  8  SHALL be the RAM read data, valid one cycle after o_raddr/o_ren is presented.
REQ-017 o_ren  output  1  SHALL be the RAM read enable.

Function
REQ-018 The controller SHALL have the FSM states IDLE, WRITE, READ, RDWAIT and ACK, with a 2-bit byte counter cnt.
REQ-019 In IDLE, i_wb_cyc=1 at an edge SHALL latch adr[aw-1:2], dat, sel and we, clear cnt, and enter WRITE if we=1 or READ if we=0.
REQ-020 WRITE: each cycle SHALL drive o_waddr={adr[aw-1:2],cnt}, o_wdata=dat[8*cnt+7:8*cnt] and o_wen=sel[cnt], then increment cnt; at cnt=3 it SHALL go to ACK.
REQ-021 READ: each cycle SHALL drive o_raddr={adr[aw-1:2],cnt} and o_ren=1, then increment cnt; at cnt=3 it SHALL go to RDWAIT.
REQ-022 Read capture: the edge ending the cycle after byte k is issued SHALL load i_rdata into o_wb_rdt[8k+7:8k]; the byte 3 capture SHALL occur at the RDWAIT->ACK edge.
REQ-023 ACK SHALL assert o_wb_ack for exactly one cycle, then return to IDLE; no request is sampled while in ACK.
REQ-024 Latency, with the request sampled at edge N: writes SHALL occupy cycles N+1..N+4 with ack in N+5; reads SHALL occupy cycles N+1..N+4 with ack in N+6.
REQ-025 o_wen and o_ren SHALL never be high in the same cycle; both SHALL be 0 outside WRITE and READ respectively.
REQ-026 Reads SHALL ignore i_wb_sel and always return the full word.
REQ-027 o_wb_rdt SHALL hold its value between reads and SHALL be unchanged by writes.
REQ-028 A write with sel=0 SHALL still take 4 cycles and ack, with o_wen=0 throughout.
REQ-029 Deasserting i_wb_cyc mid-transaction SHALL NOT abort it; the transaction completes and acks.
REQ-030 Changes on the Wishbone inputs after the request is latched SHALL have no effect until the next IDLE.
REQ-031 The top word (adr[aw-1:2] all ones) SHALL address bytes depth-4..depth-1 with no wrap into word 0.

Reset
REQ-032 While i_rst_n=0, the outputs SHALL be: state IDLE, cnt=0, o_wb_rdt=0, o_wb_ack=0, o_wen=0, o_ren=0, o_waddr=0, o_raddr=0 and o_wdata=0.
REQ-033 Reset asserted mid-transaction SHALL abort it immediately, with no ack and no further RAM enables; partially written bytes remain in the RAM.
REQ-034 The first request SHALL be sampled at the first rising edge after i_rst_n deasserts.

Verification
REQ-035 Write adr=0x10, dat=0xDEADBEEF, sel=0xF -> o_wen high in cycles N+1..N+4 at addresses 0x10..0x13 with data EF, BE, AD, DE; ack in N+5.
REQ-036 Read back adr=0x10 from a behavioural 1-cycle RAM model -> o_wb_rdt=0xDEADBEEF while ack is high in N+6; o_ren high for exactly 4 cycles.
REQ-037 Write adr=0x20, dat=0x11223344, sel=0b0101 over a pre-filled word 0xAAAAAAAA -> a subsequent read returns 0xAA22AA44.
REQ-038 Read at adr=depth-4 with depth=256 -> o_raddr takes 0xFC..0xFF, and i_wb_cyc dropped in cycle N+2 still yields an ack in N+6.
REQ-039 Reset pulse at cycle N+2 of a write -> o_wen=0 at once, no ack, all outputs at reset values; a new read after release completes normally.
REQ-040 A random mix of 1000 reads and writes against a scoreboard -> every ack matches the expected latency, o_wen&o_ren is never 1, and every read matches the model.
